// File: rtl/mem_l2_arb_pkg.sv
// mem_l2_arb_pkg: shared codes, states and request bundle
// for the two-port L2 tile arbiter.
package mem_l2_arb_pkg;

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
  localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

  localparam logic [4:0] UMEM_OPM_READY   = 5'b00000;
  localparam logic [4:0] UMEM_OPM_RD_TILE = 5'b01000;
  localparam logic [4:0] UMEM_OPM_WR_TILE = 5'b10000;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [4:0]   opm;
    logic [127:0] data;
  } l2_req_t;

  function automatic logic is_req(input logic [4:0] opm);
    return opm[4:3] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_l2_arb_mux.sv
// mem_l2_arb_mux: 2:1 request mux toward the L2,
// forced to an idle bundle outside the grant phase.
module mem_l2_arb_mux
  import mem_l2_arb_pkg::*;
(
  input  l2_req_t port_a,
  input  l2_req_t port_b,
  input  logic    sel,
  input  logic    active,
  output l2_req_t req
);

  // pass the granted port through only while granting
  always_comb begin
    req = '0;
    if (active) begin
      req = sel ? port_b : port_a;
    end
  end

endmodule

// File: rtl/mem_l2_arb.sv
// mem_l2_arb: shares one L2 tile port between two L1 requesters
// with round-robin priority and a per-access hold watchdog.
module mem_l2_arb
  import mem_l2_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  memAddrA,
  input  logic [4:0]   memOpmA,
  input  logic [127:0] memDataInA,
  output logic [127:0] memDataOutA,
  output logic [1:0]   memOKA,
  input  logic [31:0]  memAddrB,
  input  logic [4:0]   memOpmB,
  input  logic [127:0] memDataInB,
  output logic [127:0] memDataOutB,
  output logic [1:0]   memOKB,
  output logic [31:0]  l2MemAddr,
  output logic [4:0]   l2MemOpm,
  output logic [127:0] l2MemDataOut,
  input  logic [127:0] l2MemDataIn,
  input  logic [1:0]   l2MemOK,
  output logic         arbBusy
);

  arb_state_t       state;
  logic             grant;
  logic             prio;
  logic [CNT_W-1:0] wd_cnt;
  logic [127:0]     rsp_data;
  logic [1:0]       rsp_code;

  logic    req_a;
  logic    req_b;
  logic    gnt_req;
  logic    wd_exp;
  logic    in_grant;
  l2_req_t port_a;
  l2_req_t port_b;
  l2_req_t l2_req;

  assign req_a    = is_req(memOpmA);
  assign req_b    = is_req(memOpmB);
  assign gnt_req  = grant ? req_b : req_a;
  assign wd_exp   = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign in_grant = (state == ARB_GRANT);

  assign port_a = '{addr: memAddrA, opm: memOpmA, data: memDataInA};
  assign port_b = '{addr: memAddrB, opm: memOpmB, data: memDataInB};

  mem_l2_arb_mux u_mux (
    .port_a (port_a),
    .port_b (port_b),
    .sel    (grant),
    .active (in_grant),
    .req    (l2_req)
  );

  assign l2MemAddr    = l2_req.addr;
  assign l2MemOpm     = l2_req.opm;
  assign l2MemDataOut = l2_req.data;
  assign arbBusy      = (state != ARB_IDLE);

  // access sequencer: pick a port, wait on the L2, hold the answer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      wd_cnt   <= '0;
      rsp_data <= '0;
      rsp_code <= UMEM_OK_READY;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (req_a || req_b) begin
            grant  <= (req_a && req_b) ? prio : req_b;
            wd_cnt <= '0;
            state  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (l2MemOK == UMEM_OK_OK) begin
            rsp_data <= l2MemDataIn;
            rsp_code <= UMEM_OK_OK;
            prio     <= ~grant;
            state    <= ARB_RELEASE;
          end else if (l2MemOK == UMEM_OK_FAULT || wd_exp) begin
            rsp_code <= UMEM_OK_FAULT;
            prio     <= ~grant;
            state    <= ARB_RELEASE;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        ARB_RELEASE: begin
          if (!gnt_req) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // requester-side response codes and returned tile
  always_comb begin
    memOKA      = UMEM_OK_READY;
    memOKB      = UMEM_OK_READY;
    memDataOutA = '0;
    memDataOutB = '0;
    if (reset) begin
      memOKA = req_a ? UMEM_OK_HOLD : UMEM_OK_READY;
      memOKB = req_b ? UMEM_OK_HOLD : UMEM_OK_READY;
      unique case (1'b1)
        state == ARB_GRANT: begin
          if (grant) memOKB = UMEM_OK_HOLD;
          else       memOKA = UMEM_OK_HOLD;
        end
        state == ARB_RELEASE: begin
          if (grant) begin
            memOKB      = rsp_code;
            memDataOutB = rsp_data;
          end else begin
            memOKA      = rsp_code;
            memDataOutA = rsp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_l2_arb.sv
// tb_mem_l2_arb: directed and random checks of the L2 arbiter
// against a transaction-level reference model.
module tb_mem_l2_arb;

  localparam int T = 16;
  localparam logic [1:0] RDY = 2'b00;
  localparam logic [1:0] OK  = 2'b01;
  localparam logic [1:0] HLD = 2'b10;
  localparam logic [1:0] FLT = 2'b11;
  localparam logic [4:0] RD  = 5'b01000;
  localparam logic [4:0] WR  = 5'b10000;

  logic clock = 1'b0;
  logic reset;
  logic [31:0]  p_addr [2];
  logic [4:0]   p_opm  [2];
  logic [127:0] p_data [2];
  logic [127:0] memDataOutA, memDataOutB;
  logic [1:0]   memOKA, memOKB;
  logic [31:0]  l2MemAddr;
  logic [4:0]   l2MemOpm;
  logic [127:0] l2MemDataOut;
  logic [127:0] l2MemDataIn;
  logic [1:0]   l2MemOK;
  logic         arbBusy;

  mem_l2_arb #(.TIMEOUT_CYC(T), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .memAddrA(p_addr[0]), .memOpmA(p_opm[0]), .memDataInA(p_data[0]),
    .memDataOutA(memDataOutA), .memOKA(memOKA),
    .memAddrB(p_addr[1]), .memOpmB(p_opm[1]), .memDataInB(p_data[1]),
    .memDataOutB(memDataOutB), .memOKB(memOKB),
    .l2MemAddr(l2MemAddr), .l2MemOpm(l2MemOpm),
    .l2MemDataOut(l2MemDataOut), .l2MemDataIn(l2MemDataIn),
    .l2MemOK(l2MemOK), .arbBusy(arbBusy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [425:0] dut_vec, exp_vec;
  assign dut_vec = {memOKA, memOKB, memDataOutA, memDataOutB,
                    l2MemAddr, l2MemOpm, l2MemDataOut, arbBusy};

  // reference model: one outstanding transaction at a time
  bit           m_act, m_done;
  int           m_port, m_turn, m_wait;
  logic [1:0]   m_code;
  logic [127:0] m_data;

  function automatic bit rq(input logic [4:0] o);
    return o[4:3] != 2'b00;
  endfunction

  task automatic model_reset();
    m_act = 0; m_done = 0; m_port = 0;
    m_turn = 0; m_wait = 0;
    m_code = RDY; m_data = '0;
  endtask

  task automatic model_out();
    logic [1:0]   ok [2];
    logic [127:0] dout [2];
    logic [31:0]  a;
    logic [4:0]   o;
    logic [127:0] d;
    ok[0] = RDY; ok[1] = RDY;
    dout[0] = '0; dout[1] = '0;
    a = '0; o = '0; d = '0;
    if (reset) begin
      for (int p = 0; p < 2; p++) ok[p] = rq(p_opm[p]) ? HLD : RDY;
      if (m_act && !m_done) begin
        a = p_addr[m_port]; o = p_opm[m_port]; d = p_data[m_port];
        ok[m_port] = HLD;
      end else if (m_act) begin
        ok[m_port] = m_code;
        dout[m_port] = m_data;
      end
    end
    exp_vec = {ok[0], ok[1], dout[0], dout[1], a, o, d,
               (reset === 1'b1) && m_act};
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      if (rq(p_opm[0]) || rq(p_opm[1])) begin
        if (rq(p_opm[0]) && rq(p_opm[1])) m_port = m_turn;
        else m_port = rq(p_opm[1]) ? 1 : 0;
        m_act = 1; m_done = 0; m_wait = 1;
      end
    end else if (!m_done) begin
      if (l2MemOK == OK) begin
        m_done = 1; m_code = OK; m_data = l2MemDataIn;
        m_turn = 1 - m_port;
      end else if (l2MemOK == FLT || m_wait == T) begin
        m_done = 1; m_code = FLT;
        m_turn = 1 - m_port;
      end else begin
        m_wait++;
      end
    end else if (!rq(p_opm[m_port])) begin
      m_act = 0;
    end
  endtask

  // L2 responder: -1 stuck at HOLD, -2 answers FAULT
  int l2_lat = 0;
  int l2_cnt = 0;
  int l2_ok_at = -1;
  bit l2_rand = 0;

  task automatic l2_drive();
    int r;
    if (l2_rand) l2MemDataIn = {$urandom, $urandom, $urandom, $urandom};
    if (l2MemOpm !== 5'd0) begin
      if (l2_cnt == 0 && l2_rand) begin
        r = $urandom_range(0, 19);
        l2_lat = (r < 2) ? -2 : (r == 2) ? -1 : (r == 3) ? 15 : r % 6;
      end
      if (l2_lat == -2) l2MemOK = FLT;
      else if (l2_cnt == l2_lat) l2MemOK = OK;
      else l2MemOK = HLD;
      if (l2MemOK == OK) l2_ok_at = cyc;
      l2_cnt++;
    end else begin
      l2MemOK = RDY;
      l2_cnt = 0;
    end
  endtask

  task automatic settle();
    #1;
    model_out();
  endtask

  task automatic advance();
    l2_drive();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
  endtask

  // requester agents for the round-robin and random runs
  bit           ag_on [2];
  int           ag_rate [2];
  int           ag_hold [2];
  int           ag_hmax = 0;
  logic [4:0]   nx_opm [2];
  logic [31:0]  nx_addr [2];
  logic [127:0] nx_data [2];

  task automatic agent_plan();
    logic [1:0] ok;
    for (int p = 0; p < 2; p++) begin
      nx_opm[p] = p_opm[p]; nx_addr[p] = p_addr[p]; nx_data[p] = p_data[p];
      ok = (p == 1) ? memOKB : memOKA;
      if (rq(p_opm[p])) begin
        if (ok == OK || ok == FLT) begin
          if (ag_hold[p] == 0) nx_opm[p] = 5'($urandom_range(0, 7));
          else ag_hold[p]--;
        end
      end else if (ag_on[p] && $urandom_range(0, 99) < ag_rate[p]) begin
        nx_opm[p]  = 5'($urandom_range(8, 31));
        nx_addr[p] = {(p == 1) ? 4'hB : 4'hA, 28'($urandom)};
        nx_data[p] = {$urandom, $urandom, $urandom, $urandom};
        ag_hold[p] = $urandom_range(0, ag_hmax);
      end
    end
  endtask

  task automatic agent_apply();
    for (int p = 0; p < 2; p++) begin
      p_opm[p] = nx_opm[p]; p_addr[p] = nx_addr[p]; p_data[p] = nx_data[p];
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      p_opm[p] = '0; p_addr[p] = '0; p_data[p] = '0;
      ag_on[p] = 0; ag_hold[p] = 0; ag_rate[p] = 0;
    end
    l2MemOK = RDY; l2MemDataIn = '0;
    l2_rand = 0; l2_lat = 0; l2_cnt = 0; l2_ok_at = -1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      p_opm[p] = RD; p_addr[p] = 32'h1234_5678; p_data[p] = '1;
    end
    l2MemOK = OK; l2MemDataIn = '1;
    model_reset();
    settle();
    n_tests++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec);
    end
    n_tests++;
    if (memOKA !== RDY || arbBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_okA got=%b busy=%b exp=00 busy=0", memOKA, arbBusy);
    end
    do_reset();
    settle();
    n_tests++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_single_read();
    logic [127:0] rd;
    int gcyc, okc;
    bit seen, dropped;
    do_reset();
    rd = 128'hDEADBEEF_00000000_00000000_00000001;
    l2MemDataIn = rd; l2_lat = 3;
    p_addr[0] = 32'h0100_0040; p_opm[0] = RD;
    gcyc = 0; seen = 0; dropped = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rd_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (l2MemOpm !== 5'd0) begin
        gcyc++;
        n_tests++;
        if (l2MemAddr !== 32'h0100_0040) begin
          n_fail++;
          $display("FAIL rd_addr got=%h exp=01000040", l2MemAddr);
        end
      end
      if (!seen && memOKA == OK) begin
        seen = 1; okc = cyc;
        n_tests++;
        if (memDataOutA !== rd) begin
          n_fail++;
          $display("FAIL rd_data got=%h exp=%h", memDataOutA, rd);
        end
        n_tests++;
        if (okc != l2_ok_at + 1 || gcyc != 4 || l2MemOpm !== 5'd0) begin
          n_fail++;
          $display("FAIL rd_lat ok@%0d l2ok@%0d grants=%0d opm=%b exp +1,4,0",
                   okc, l2_ok_at, gcyc, l2MemOpm);
        end
      end
      if (dropped && !arbBusy) break;
      advance();
      if (seen) begin
        p_opm[0] = '0;
        dropped = 1;
      end
    end
    n_tests++;
    if (!(dropped && arbBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL rd_idle seen=%0d busy=%b exp done and idle", seen, arbBusy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [$];
    logic [4:0] prev;
    do_reset();
    ag_on[0] = 1; ag_on[1] = 1;
    ag_rate[0] = 100; ag_rate[1] = 100; ag_hmax = 0;
    l2_lat = 1; l2MemDataIn = 128'h0F0F_1234;
    agent_plan();
    agent_apply();
    prev = '0;
    for (int i = 0; i < 60 && order.size() < 3; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rr_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (l2MemOpm !== 5'd0 && prev === 5'd0) order.push_back(l2MemAddr[31:28]);
      prev = l2MemOpm;
      agent_plan();
      advance();
      agent_apply();
    end
    n_tests++;
    if (order.size() != 3) begin
      n_fail++;
      $display("FAIL rr_count got=%0d exp=3", order.size());
    end else if (order[0] !== 4'hA || order[1] !== 4'hB || order[2] !== 4'hA) begin
      n_fail++;
      $display("FAIL rr_order got=%h,%h,%h exp=a,b,a", order[0], order[1], order[2]);
    end
  endtask

  task automatic test_b_write();
    logic [127:0] wd;
    bit seen, dropped;
    do_reset();
    wd = 128'h55555555_55555555_55555555_555555AA;
    l2_lat = 2;
    p_addr[1] = 32'h0200_0100; p_opm[1] = WR; p_data[1] = wd;
    seen = 0; dropped = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL wr_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (l2MemOpm !== 5'd0) begin
        n_tests++;
        if (l2MemDataOut !== wd || l2MemOpm !== WR || l2MemAddr !== 32'h0200_0100) begin
          n_fail++;
          $display("FAIL wr_pass got=%h/%b/%h exp=%h/%b/02000100",
                   l2MemDataOut, l2MemOpm, l2MemAddr, wd, WR);
        end
      end
      n_tests++;
      if (memOKA !== RDY || memDataOutA !== '0) begin
        n_fail++;
        $display("FAIL wr_a_quiet got=%b exp=00", memOKA);
      end
      if (memOKB == OK) seen = 1;
      if (dropped && !arbBusy) break;
      advance();
      if (seen) begin
        p_opm[1] = '0;
        dropped = 1;
      end
    end
    n_tests++;
    if (!seen || arbBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done seen=%0d busy=%b exp 1,0", seen, arbBusy);
    end
  endtask

  task automatic test_watchdog(input int lat);
    int gcyc;
    bit seen, dropped;
    logic [127:0] rd;
    do_reset();
    rd = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;
    l2MemDataIn = rd; l2_lat = lat;
    p_addr[0] = 32'h0300_0000; p_opm[0] = RD;
    gcyc = 0; seen = 0; dropped = 0;
    for (int i = 0; i < 60; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL wd_vec lat=%0d cyc=%0d got=%h exp=%h", lat, cyc, dut_vec, exp_vec);
      end
      if (l2MemOpm !== 5'd0) begin
        gcyc++;
      end else if (gcyc > 0 && !seen) begin
        seen = 1;
        n_tests++;
        if (gcyc != T) begin
          n_fail++;
          $display("FAIL wd_grants lat=%0d got=%0d exp=%0d", lat, gcyc, T);
        end
        n_tests++;
        if (lat < 0 && memOKA !== FLT) begin
          n_fail++;
          $display("FAIL wd_fault got=%b exp=11", memOKA);
        end else if (lat >= 0 && (memOKA !== OK || memDataOutA !== rd)) begin
          n_fail++;
          $display("FAIL wd_ok_wins got=%b/%h exp=01/%h", memOKA, memDataOutA, rd);
        end
      end
      if (dropped && !arbBusy) break;
      advance();
      if (seen) begin
        p_opm[0] = '0;
        dropped = 1;
      end
    end
    n_tests++;
    if (!(dropped && arbBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL wd_idle lat=%0d seen=%0d busy=%b exp done and idle", lat, seen, arbBusy);
    end
  endtask

  task automatic test_hold_release();
    logic [127:0] rd;
    int rel, a_drop, b_gnt;
    bit b_done, b_dropped;
    do_reset();
    rd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    l2MemDataIn = rd; l2_lat = 0;
    p_addr[0] = 32'h0400_0000; p_opm[0] = RD;
    rel = 0; a_drop = -1; b_gnt = -1; b_done = 0; b_dropped = 0;
    for (int i = 0; i < 50; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL hr_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (a_drop < 0 && memOKA == OK) begin
        rel++;
        n_tests++;
        if (memDataOutA !== rd || l2MemOpm !== 5'd0) begin
          n_fail++;
          $display("FAIL hr_stable got=%h/%b exp=%h/00000", memDataOutA, l2MemOpm, rd);
        end
        if (rq(p_opm[1])) begin
          n_tests++;
          if (memOKB !== HLD) begin
            n_fail++;
            $display("FAIL hr_b_wait got=%b exp=10", memOKB);
          end
        end
      end
      if (b_gnt < 0 && l2MemOpm !== 5'd0 && l2MemAddr === 32'h0B00_0080) b_gnt = cyc;
      if (memOKB == OK) b_done = 1;
      if (b_dropped && !arbBusy) break;
      advance();
      if (rel == 2) begin
        p_addr[1] = 32'h0B00_0080; p_opm[1] = RD;
      end
      if (rel == 6 && a_drop < 0) begin
        p_opm[0] = '0; a_drop = cyc;
      end
      if (b_done) begin
        p_opm[1] = '0; b_dropped = 1;
      end
    end
    n_tests++;
    if (a_drop < 0 || b_gnt <= a_drop || !b_dropped || arbBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL hr_order a_drop=%0d b_gnt=%0d b_done=%0d exp b after a",
               a_drop, b_gnt, b_dropped);
    end
  endtask

  task automatic test_reset_mid_grant();
    int gcyc;
    bit seen, dropped;
    logic [127:0] rd;
    do_reset();
    l2_lat = -1;
    p_addr[0] = 32'h0500_0000; p_opm[0] = RD;
    gcyc = 0;
    for (int i = 0; i < 10 && gcyc < 3; i++) begin
      settle();
      if (l2MemOpm !== 5'd0) gcyc++;
      if (gcyc < 3) advance();
    end
    #2;
    reset = 1'b0;
    model_reset();
    settle();
    n_tests++;
    if (dut_vec !== exp_vec || memOKA !== RDY || l2MemOpm !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_async grants=%0d got=%h exp=%h", gcyc, dut_vec, exp_vec);
    end
    advance();
    reset = 1'b1;
    rd = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
    l2MemDataIn = rd; l2_lat = 2;
    seen = 0; dropped = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rst_again_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (!seen && memOKA == OK) begin
        seen = 1;
        n_tests++;
        if (memDataOutA !== rd) begin
          n_fail++;
          $display("FAIL rst_again_data got=%h exp=%h", memDataOutA, rd);
        end
      end
      if (dropped && !arbBusy) break;
      advance();
      if (seen) begin
        p_opm[0] = '0; dropped = 1;
      end
    end
    n_tests++;
    if (!(dropped && arbBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL rst_again_done seen=%0d busy=%b exp done and idle", seen, arbBusy);
    end
  endtask

  task automatic test_random();
    do_reset();
    ag_on[0] = 1; ag_on[1] = 1;
    ag_rate[0] = 30; ag_rate[1] = 30; ag_hmax = 3;
    l2_rand = 1;
    for (int i = 0; i < 600; i++) begin
      settle();
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      agent_plan();
      advance();
      agent_apply();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_b_write();
    test_watchdog(-1);
    test_watchdog(T - 1);
    test_hold_release();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
